// File: rtl/fifo_sync_pkg.sv
// Shared types for the synchronous FIFO: the bundle of one-cycle error pulses.
package fifo_sync_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

endpackage

// File: rtl/fifo_sync_pdpram.sv
// Pseudo-dual-port RAM: one write port, one registered read port with a
// read-valid strobe. Storage is not reset; only the read register is.
module PseudoDualPortRAM #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     i_wclk,
    input  logic                     i_rclk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [ADDRESS_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic                     i_re,
    input  logic [ADDRESS_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata,
    output logic                     o_rvalid
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    always_ff @(posedge i_wclk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Read data holds its last value when no read is issued.
    always_ff @(posedge i_rclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= i_re;
            if (i_re)
                r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: wrap-bit pointers around a pseudo-dual-port RAM, with
// flags and count derived directly from the registered pointers.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   WriteEnable_i,
    input  logic [DATA_WIDTH-1:0]  Data_i,
    input  logic                   ReadEnable_i,
    output logic [DATA_WIDTH-1:0]  Data_o,
    output logic                   Valid_o,
    output logic                   Full_o,
    output logic                   Empty_o,
    output logic [ADDRESS_WIDTH:0] Count_o,
    output logic                   Overflow_o,
    output logic                   Underflow_o
);
    localparam int PW = ADDRESS_WIDTH + 1;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    fifo_err_t     r_err;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[ADDRESS_WIDTH-1:0] == r_rptr[ADDRESS_WIDTH-1:0]) &&
                      (r_wptr[ADDRESS_WIDTH] != r_rptr[ADDRESS_WIDTH]);
    // Gating on the flags also keeps read and write addresses apart.
    assign w_wr_acc = WriteEnable_i && !w_full;
    assign w_rd_acc = ReadEnable_i && !w_empty;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_err  <= '0;
        end else begin
            if (w_wr_acc)
                r_wptr <= r_wptr + PW'(1);
            if (w_rd_acc)
                r_rptr <= r_rptr + PW'(1);
            r_err.overflow  <= WriteEnable_i && w_full;
            r_err.underflow <= ReadEnable_i && w_empty;
        end
    end

    PseudoDualPortRAM #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram (
        .i_wclk   (Clock),
        .i_rclk   (Clock),
        .i_rst_n  (Reset),
        .i_we     (w_wr_acc),
        .i_waddr  (r_wptr[ADDRESS_WIDTH-1:0]),
        .i_wdata  (Data_i),
        .i_re     (w_rd_acc),
        .i_raddr  (r_rptr[ADDRESS_WIDTH-1:0]),
        .o_rdata  (Data_o),
        .o_rvalid (Valid_o)
    );

    assign Full_o      = w_full;
    assign Empty_o     = w_empty;
    assign Count_o     = r_wptr - r_rptr;
    assign Overflow_o  = r_err.overflow;
    assign Underflow_o = r_err.underflow;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync at depth 4: fill/drain, overflow, underflow,
// simultaneous access, pointer wrap and asynchronous reset.
module tb_fifo_sync;
    localparam int AW = 2;
    localparam int DW = 8;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          WriteEnable_i = 1'b0;
    logic [DW-1:0] Data_i = '0;
    logic          ReadEnable_i = 1'b0;
    logic [DW-1:0] Data_o;
    logic          Valid_o;
    logic          Full_o;
    logic          Empty_o;
    logic [AW:0]   Count_o;
    logic          Overflow_o;
    logic          Underflow_o;

    int n_chk  = 0;
    int n_pass = 0;

    fifo_sync #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .WriteEnable_i (WriteEnable_i),
        .Data_i        (Data_i),
        .ReadEnable_i  (ReadEnable_i),
        .Data_o        (Data_o),
        .Valid_o       (Valid_o),
        .Full_o        (Full_o),
        .Empty_o       (Empty_o),
        .Count_o       (Count_o),
        .Overflow_o    (Overflow_o),
        .Underflow_o   (Underflow_o)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [DW-1:0] d, input logic re);
        WriteEnable_i = we;
        Data_i        = d;
        ReadEnable_i  = re;
    endtask

    task automatic chk_read(input string tag, input logic [DW-1:0] exp);
        chk({tag, "_valid"}, Valid_o, 1);
        chk({tag, "_data"}, Data_o, exp);
    endtask

    initial begin
        #1;
        chk("rst_count", Count_o, 0);
        chk("rst_empty", Empty_o, 1);
        chk("rst_full", Full_o, 0);
        chk("rst_valid", Valid_o, 0);
        chk("rst_data", Data_o, 0);
        chk("rst_ovf", Overflow_o, 0);
        chk("rst_udf", Underflow_o, 0);
        @(negedge Clock);
        Reset = 1'b1;

        // Fill: write accepted on the very first edge after reset release.
        for (int i = 0; i < 4; i++) begin
            drive(1, DW'((i + 1) * 8'h11), 0);
            step();
            chk("fill_count", Count_o, i + 1);
        end
        drive(0, 0, 0);
        chk("fill_full", Full_o, 1);
        chk("fill_empty", Empty_o, 0);

        // Overflow while full.
        drive(1, 8'h55, 0);
        step();
        drive(0, 0, 0);
        chk("ovf_pulse", Overflow_o, 1);
        chk("ovf_count", Count_o, 4);
        step();
        chk("ovf_clear", Overflow_o, 0);

        // Drain; 0x55 must never appear.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1);
            step();
            chk_read("drain", DW'((i + 1) * 8'h11));
        end
        drive(0, 0, 0);
        step();
        chk("drain_valid_off", Valid_o, 0);
        chk("drain_empty", Empty_o, 1);
        chk("drain_count", Count_o, 0);
        chk("drain_hold", Data_o, 8'h44);

        // Underflow while empty.
        drive(0, 0, 1);
        step();
        drive(0, 0, 0);
        chk("udf_pulse", Underflow_o, 1);
        chk("udf_valid", Valid_o, 0);
        chk("udf_data", Data_o, 8'h44);
        step();
        chk("udf_clear", Underflow_o, 0);

        // Full + read + write: read wins, write rejected.
        for (int i = 0; i < 4; i++) begin
            drive(1, DW'(8'hA1 + i), 0);
            step();
        end
        drive(1, 8'h66, 1);
        step();
        chk_read("fullrw", 8'hA1);
        chk("fullrw_ovf", Overflow_o, 1);
        chk("fullrw_count", Count_o, 3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1);
            step();
            chk_read("fullrw_drain", DW'(8'hA2 + i));
        end
        drive(0, 0, 0);
        step();
        chk("fullrw_empty", Empty_o, 1);

        // Empty + read + write: write wins, read rejected.
        drive(1, 8'h77, 1);
        step();
        chk("emptyrw_count", Count_o, 1);
        chk("emptyrw_udf", Underflow_o, 1);
        chk("emptyrw_valid", Valid_o, 0);
        drive(0, 0, 1);
        step();
        chk_read("emptyrw_read", 8'h77);

        // Wrap-around: steady two-deep stream.
        drive(1, 8'h80, 0);
        step();
        drive(1, 8'h81, 0);
        step();
        chk("wrap_start", Count_o, 2);
        for (int i = 0; i < 10; i++) begin
            drive(1, DW'(8'h82 + i), 1);
            step();
            chk_read("wrap", DW'(8'h80 + i));
            chk("wrap_count", Count_o, 2);
            chk("wrap_flags", {Overflow_o, Underflow_o, Full_o, Empty_o}, 0);
        end
        drive(0, 0, 1);
        step();
        chk_read("wrap_tail0", 8'h8A);
        drive(1, 8'hC1, 1);
        step();
        chk_read("wrap_tail1", 8'h8B);

        // Asynchronous reset mid-stream with three words stored.
        drive(1, 8'hC2, 0);
        step();
        drive(1, 8'hC3, 0);
        step();
        drive(0, 0, 0);
        chk("pre_rst_count", Count_o, 3);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_rst_count", Count_o, 0);
        chk("async_rst_empty", Empty_o, 1);
        chk("async_rst_data", Data_o, 0);
        chk("async_rst_valid", Valid_o, 0);
        @(negedge Clock);
        Reset = 1'b1;
        drive(1, 8'h99, 0);
        step();
        chk("post_rst_count", Count_o, 1);
        drive(0, 0, 1);
        step();
        chk_read("post_rst_read", 8'h99);
        drive(0, 0, 0);
        step();
        chk("post_rst_empty", Empty_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4, meaning log2 of FIFO depth (DEPTH = 2**ADDRESS_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning word width.
REQ-003 SHALL have port Clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port WriteEnable_i  input  1  write request for Data_i this cycle.
REQ-006 SHALL have port Data_i  input  DATA_WIDTH  write data.
REQ-007 SHALL have port ReadEnable_i  input  1  read request this cycle.
REQ-008 SHALL have port Data_o  output  DATA_WIDTH  read data, valid when Valid_o=1.
REQ-009 SHALL have port Valid_o  output  1  one-cycle pulse: Data_o holds the word from an accepted read.
REQ-010 SHALL have port Full_o  output  1  FIFO holds DEPTH words.
REQ-011 SHALL have port Empty_o  output  1  FIFO holds 0 words.
REQ-012 SHALL have port Count_o  output  ADDRESS_WIDTH+1  number of stored words, 0..DEPTH.
REQ-013 SHALL have port Overflow_o  output  1  one-cycle pulse: write rejected because full.
REQ-014 SHALL have port Underflow_o  output  1  one-cycle pulse: read rejected because empty.

Function
REQ-015 SHALL accept a write iff WriteEnable_i=1 and Full_o=0 (Full_o as registered at that edge); storing Data_i at write pointer, pointer +1.
REQ-016 SHALL accept a read iff ReadEnable_i=1 and Empty_o=0; reading the word at read pointer, pointer +1.
REQ-017 SHALL present a read word on Data_o with Valid_o=1 exactly one cycle after the accepted-read edge (latency 1).
REQ-018 SHALL hold Data_o at its last value when no read is accepted; Valid_o=0 in those cycles.
REQ-019 SHALL use read/write pointers of ADDRESS_WIDTH+1 bits; low bits address memory, MSB is the wrap bit; pointers wrap modulo 2*DEPTH.
REQ-020 SHALL derive Empty_o = (pointers equal), Full_o = (low bits equal, MSBs differ), Count_o = write pointer - read pointer modulo 2*DEPTH, all registered/consistent in the same cycle.
REQ-021 SHALL, on simultaneous read and write when neither full nor empty, accept both; Count_o unchanged.
REQ-022 SHALL, on simultaneous read and write when full, accept the read, reject the write, pulse Overflow_o; Count_o becomes DEPTH-1.
REQ-023 SHALL, on simultaneous read and write when empty, accept the write, reject the read, pulse Underflow_o; Count_o becomes 1; no Valid_o next cycle.
REQ-024 SHALL never read and write the same memory address in one cycle (guaranteed by REQ-015/016 gating).
REQ-025 SHALL preserve FIFO order across pointer wrap-around.

Reset
REQ-026 SHALL, while Reset=0, asynchronously force: pointers 0, Data_o 0, Valid_o 0, Full_o 0, Empty_o 1, Count_o 0, Overflow_o 0, Underflow_o 0.
REQ-027 SHALL, on reset mid-operation, discard all stored words; memory contents need not be cleared and are never observable afterwards.
REQ-028 SHALL accept a write on the first rising edge after Reset deasserts.

Structure
REQ-029 SHALL instantiate exactly one sub-module, the team's pseudo-dual-port RAM (PseudoDualPortRAM), with both clocks tied to Clock, Reset passed through, and read/write enables driven by the accepted-read and accepted-write strobes.
REQ-030 SHALL take Data_o directly from the RAM read register; no extra output pipeline stage.
REQ-031 SHALL keep pointer/flag logic in fifo_sync; no shared package is required; ADDRESS_WIDTH/DATA_WIDTH are the only constants.

Verification (ADDRESS_WIDTH=2, DEPTH=4, DATA_WIDTH=8)
REQ-032 SHALL cover reset: Reset=0 mid-stream with Count_o=3 -> immediately Count_o=0, Empty_o=1, Data_o=0x00, Valid_o=0.
REQ-033 SHALL cover fill/drain: write 0x11,0x22,0x33,0x44 -> Full_o=1, Count_o=4; read 4 times -> Data_o 0x11,0x22,0x33,0x44 each 1 cycle after request with Valid_o=1; then Empty_o=1.
REQ-034 SHALL cover overflow: when full, write 0x55 -> Overflow_o pulses 1 cycle, Count_o stays 4, subsequent reads never return 0x55.
REQ-035 SHALL cover underflow: when empty, ReadEnable_i=1 -> Underflow_o pulses, Valid_o stays 0, Data_o unchanged.
REQ-036 SHALL cover simultaneous events: full + read + write 0x66 -> read returns oldest, write rejected, Count_o=3; empty + read + write 0x77 -> Count_o=1, next read returns 0x77.
REQ-037 SHALL cover wrap-around: 10 cycles of write+read with Count_o=2 start, values 0x80..0x89 -> outputs in order, Count_o constant 2, no flag pulses.
